// File: rtl/conv_window_sched.sv
// Sequencer for the 3x3 convolution window: walks the image column by column,
// issues three-row BRAM reads, shifts the window and hands complete windows downstream.
module conv_window_sched #(
   parameter int unsigned IMG_W  = 28,
   parameter int unsigned IMG_H  = 28,
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr_r1,
   output logic [ADDR_W-1:0] rd_addr_r2,
   output logic [ADDR_W-1:0] rd_addr_r3,
   output logic              win_wr_en,
   output logic              win_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  win_row,
   output logic [CNT_W-1:0]  win_col
);

   localparam logic [CNT_W-1:0]  C_COLS     = CNT_W'(IMG_W);
   localparam logic [CNT_W-1:0]  C_LAST_ROW = CNT_W'(IMG_H - 3);
   localparam logic [CNT_W-1:0]  C_TWO      = CNT_W'(2);
   localparam logic [ADDR_W-1:0] A_ROW1     = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] A_ROW2     = ADDR_W'(2 * IMG_W);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_ROW_END,
      S_FIN
   } state_t;

   state_t             r_state;
   state_t             w_next;

   logic [CNT_W-1:0]   r_row;
   logic [CNT_W-1:0]   r_col;
   logic [CNT_W-1:0]   r_shift_cnt;
   logic [CNT_W-1:0]   r_win_row;
   logic [CNT_W-1:0]   r_win_col;
   logic [ADDR_W-1:0]  r_addr1;
   logic [ADDR_W-1:0]  r_addr2;
   logic [ADDR_W-1:0]  r_addr3;
   logic               r_pend;
   logic               r_win_valid;

   logic               w_ok;
   logic               w_rd_en;
   logic               w_wr_en;
   logic               w_accept;
   logic               w_next_row;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state and the handshake-gated read/shift strobes
   always_comb begin
      w_next     = r_state;
      w_ok       = 1'b0;
      w_rd_en    = 1'b0;
      w_wr_en    = 1'b0;
      w_accept   = 1'b0;
      w_next_row = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = S_FETCH;
            end
         end
         S_FETCH: begin
            // An unconsumed window blocks both the shift and the read feeding it
            w_ok    = !(r_win_valid && !out_ready);
            w_rd_en = w_ok && (r_col < C_COLS);
            w_wr_en = w_ok && r_pend;
            if ((r_col == C_COLS) && !r_pend) begin
               w_next = S_ROW_END;
            end
         end
         S_ROW_END: begin
            if (!r_win_valid) begin
               if (r_row == C_LAST_ROW) begin
                  w_next = S_FIN;
               end else begin
                  w_next_row = 1'b1;
                  w_next     = S_FETCH;
               end
            end
         end
         S_FIN: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Counters, address pointers and the window-valid flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row       <= '0;
         r_col       <= '0;
         r_shift_cnt <= '0;
         r_win_row   <= '0;
         r_win_col   <= '0;
         r_addr1     <= '0;
         r_addr2     <= '0;
         r_addr3     <= '0;
         r_pend      <= 1'b0;
         r_win_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_row       <= '0;
            r_col       <= '0;
            r_shift_cnt <= '0;
            r_pend      <= 1'b0;
            r_addr1     <= '0;
            r_addr2     <= A_ROW1;
            r_addr3     <= A_ROW2;
         end
         // Pointers already sit on the next row's first column after a full row
         if (w_next_row) begin
            r_row       <= r_row + CNT_W'(1);
            r_col       <= '0;
            r_shift_cnt <= '0;
         end
         if ((r_state == S_FETCH) && w_ok) begin
            r_pend <= w_rd_en;
         end
         if (w_rd_en) begin
            r_col   <= r_col + CNT_W'(1);
            r_addr1 <= r_addr1 + ADDR_W'(1);
            r_addr2 <= r_addr2 + ADDR_W'(1);
            r_addr3 <= r_addr3 + ADDR_W'(1);
         end
         if (w_wr_en) begin
            r_shift_cnt <= r_shift_cnt + CNT_W'(1);
         end
         if (w_wr_en && (r_shift_cnt >= C_TWO)) begin
            r_win_valid <= 1'b1;
            r_win_row   <= r_row;
            r_win_col   <= r_shift_cnt - C_TWO;
         end else if (out_ready) begin
            r_win_valid <= 1'b0;
         end
      end
   end

   assign busy       = (r_state == S_FETCH) || (r_state == S_ROW_END);
   assign done       = (r_state == S_FIN);
   assign rd_en      = w_rd_en;
   assign win_wr_en  = w_wr_en;
   assign rd_addr_r1 = r_addr1;
   assign rd_addr_r2 = r_addr2;
   assign rd_addr_r3 = r_addr3;
   assign win_valid  = r_win_valid;
   assign win_row    = r_win_row;
   assign win_col    = r_win_col;

endmodule

// File: tb/tb_conv_window_sched.sv
// Randomized self-checking bench for conv_window_sched: a 5x4 and a 3x3 instance
// checked against raster-order read/window expectations computed from image geometry.
module tb_conv_window_sched;

   logic       clk;
   logic       rst_n;
   logic       start     [2];
   logic       busy      [2];
   logic       done      [2];
   logic       rd_en     [2];
   logic [9:0] addr1     [2];
   logic [9:0] addr2     [2];
   logic [9:0] addr3     [2];
   logic       win_wr_en [2];
   logic       win_valid [2];
   logic       out_ready [2];
   logic [7:0] win_row   [2];
   logic [7:0] win_col   [2];

   int n_chk;
   int n_fail;

   // Reference model state per instance
   int   rd_idx    [2];
   int   win_idx   [2];
   int   wr_cnt    [2];
   int   done_cnt  [2];
   logic was_stall [2];
   logic [7:0] held_row [2];
   logic [7:0] held_col [2];
   logic mon_en    [2];
   logic rnd       [2];

   conv_window_sched #(.IMG_W(5), .IMG_H(4), .ADDR_W(10), .CNT_W(8)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
      .rd_en(rd_en[0]), .rd_addr_r1(addr1[0]), .rd_addr_r2(addr2[0]), .rd_addr_r3(addr3[0]),
      .win_wr_en(win_wr_en[0]), .win_valid(win_valid[0]), .out_ready(out_ready[0]),
      .win_row(win_row[0]), .win_col(win_col[0])
   );

   conv_window_sched #(.IMG_W(3), .IMG_H(3), .ADDR_W(10), .CNT_W(8)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
      .rd_en(rd_en[1]), .rd_addr_r1(addr1[1]), .rd_addr_r2(addr2[1]), .rd_addr_r3(addr3[1]),
      .win_wr_en(win_wr_en[1]), .win_valid(win_valid[1]), .out_ready(out_ready[1]),
      .win_row(win_row[1]), .win_col(win_col[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int img_w(input int d);
      return (d == 0) ? 5 : 3;
   endfunction

   function automatic int img_h(input int d);
      return (d == 0) ? 4 : 3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   // Scoreboard: reads in address order, windows in raster order, stall hold rules
   always @(negedge clk) begin
      int w;
      int h;
      int m;
      for (int d = 0; d < 2; d++) begin
         if (mon_en[d]) begin
            w = img_w(d);
            h = img_h(d);
            if (rd_en[d]) begin
               chk("rd_in_range", 32'(rd_idx[d] < w * (h - 2)), 32'd1);
               chk("rd_addr_r1", 32'(addr1[d]), 32'(rd_idx[d]));
               chk("rd_addr_r2", 32'(addr2[d]), 32'(rd_idx[d] + w));
               chk("rd_addr_r3", 32'(addr3[d]), 32'(rd_idx[d] + 2 * w));
               rd_idx[d]++;
            end
            if (win_valid[d] && out_ready[d]) begin
               m = win_idx[d];
               chk("win_in_range", 32'(m < (w - 2) * (h - 2)), 32'd1);
               chk("win_row", 32'(win_row[d]), 32'(m / (w - 2)));
               chk("win_col", 32'(win_col[d]), 32'(m % (w - 2)));
               chk("win_shifts", 32'(wr_cnt[d]), 32'((m / (w - 2)) * w + (m % (w - 2)) + 3));
               win_idx[d]++;
            end
            if (win_valid[d] && !out_ready[d]) begin
               chk("stall_rd_en", 32'(rd_en[d]), 32'd0);
               chk("stall_wr_en", 32'(win_wr_en[d]), 32'd0);
            end
            if (was_stall[d]) begin
               chk("hold_valid", 32'(win_valid[d]), 32'd1);
               chk("hold_row", 32'(win_row[d]), 32'(held_row[d]));
               chk("hold_col", 32'(win_col[d]), 32'(held_col[d]));
            end
            was_stall[d] = win_valid[d] && !out_ready[d];
            held_row[d]  = win_row[d];
            held_col[d]  = win_col[d];
            if (win_wr_en[d]) wr_cnt[d]++;
            if (done[d]) begin
               done_cnt[d]++;
               chk("done_windows", 32'(win_idx[d]), 32'((w - 2) * (h - 2)));
               chk("done_shifts", 32'(wr_cnt[d]), 32'(w * (h - 2)));
            end
         end
      end
   end

   // Random back-pressure driver
   always @(posedge clk) begin
      #1;
      for (int d = 0; d < 2; d++) begin
         if (rnd[d]) out_ready[d] = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic new_pass(input int d);
      rd_idx[d]    = 0;
      win_idx[d]   = 0;
      wr_cnt[d]    = 0;
      done_cnt[d]  = 0;
      was_stall[d] = 1'b0;
      mon_en[d]    = 1'b1;
   endtask

   task automatic start_pulse(input int d);
      @(posedge clk);
      #1 start[d] = 1'b1;
      @(posedge clk);
      #1 start[d] = 1'b0;
   endtask

   task automatic wait_done(input int d);
      int n;
      n = 0;
      while (!done[d] && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("done_timeout", 32'(n < 2000), 32'd1);
      repeat (3) @(negedge clk);
      chk("pass_windows", 32'(win_idx[d]), 32'((img_w(d) - 2) * (img_h(d) - 2)));
      chk("pass_done_count", 32'(done_cnt[d]), 32'd1);
      chk("idle_busy", 32'(busy[d]), 32'd0);
   endtask

   task automatic chk_zero(input int d, input string tag);
      chk({tag, "_busy"}, 32'(busy[d]), 32'd0);
      chk({tag, "_done"}, 32'(done[d]), 32'd0);
      chk({tag, "_rd_en"}, 32'(rd_en[d]), 32'd0);
      chk({tag, "_wr_en"}, 32'(win_wr_en[d]), 32'd0);
      chk({tag, "_valid"}, 32'(win_valid[d]), 32'd0);
      chk({tag, "_addr1"}, 32'(addr1[d]), 32'd0);
      chk({tag, "_addr2"}, 32'(addr2[d]), 32'd0);
      chk({tag, "_addr3"}, 32'(addr3[d]), 32'd0);
      chk({tag, "_row"}, 32'(win_row[d]), 32'd0);
      chk({tag, "_col"}, 32'(win_col[d]), 32'd0);
   endtask

   initial begin
      int n;
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      for (int d = 0; d < 2; d++) begin
         start[d]     = 1'b0;
         out_ready[d] = 1'b1;
         mon_en[d]    = 1'b0;
         rnd[d]       = 1'b0;
         new_pass(d);
         mon_en[d]    = 1'b0;
      end
      #2;
      chk_zero(0, "reset_a");
      chk_zero(1, "reset_b");
      @(negedge clk);
      rst_n = 1'b1;

      // Free-flowing pass: cycle-exact latency profile
      new_pass(0);
      start_pulse(0);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         chk("lat_rd_en", 32'(rd_en[0]), 32'(c >= 1 && c <= 5));
         chk("lat_wr_en", 32'(win_wr_en[0]), 32'(c >= 2 && c <= 6));
         chk("lat_valid", 32'(win_valid[0]), 32'(c >= 5 && c <= 7));
         chk("lat_busy", 32'(busy[0]), 32'd1);
         if (c >= 5 && c <= 7) chk("lat_col", 32'(win_col[0]), 32'(c - 5));
      end
      wait_done(0);

      // Back-pressure during cycles 5-8
      new_pass(0);
      start_pulse(0);
      for (int c = 1; c <= 10; c++) begin
         if (c == 5) out_ready[0] = 1'b0;
         if (c == 9) out_ready[0] = 1'b1;
         @(negedge clk);
         if (c >= 5 && c <= 8) begin
            chk("stall_valid", 32'(win_valid[0]), 32'd1);
            chk("stall_col", 32'(win_col[0]), 32'd0);
         end
         @(posedge clk);
         #1;
      end
      rnd[0] = 1'b1;
      wait_done(0);

      // Random back-pressure with start re-pulsed while busy
      for (int p = 0; p < 3; p++) begin
         new_pass(0);
         start_pulse(0);
         repeat (4 + p * 5) @(posedge clk);
         #1 start[0] = 1'b1;
         @(posedge clk);
         #1 start[0] = 1'b0;
         chk("repulse_busy", 32'(busy[0]), 32'd1);
         wait_done(0);
      end

      // Asynchronous reset in the middle of row 1, then a fresh pass
      rnd[0]       = 1'b0;
      out_ready[0] = 1'b1;
      new_pass(0);
      start_pulse(0);
      n = 0;
      while (rd_idx[0] < 7 && n < 200) begin
         @(posedge clk);
         n++;
      end
      chk("mid_row_timeout", 32'(n < 200), 32'd1);
      @(posedge clk);
      #1 mon_en[0] = 1'b0;
      #1 rst_n = 1'b0;
      #1 chk_zero(0, "async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      new_pass(0);
      rnd[0] = 1'b1;
      start_pulse(0);
      wait_done(0);

      // Minimum 3x3 image: one window, with steady and random back-pressure
      new_pass(1);
      start_pulse(1);
      wait_done(1);
      rnd[1] = 1'b1;
      for (int p = 0; p < 3; p++) begin
         new_pass(1);
         start_pulse(1);
         wait_done(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_window_sched.md
Name: conv_window_sched

Overview:
- Sequencer for the 3x3 convolution window shift register in the NPU feature-map path.
- Walks an IMG_H x IMG_W image held in three row-aligned BRAM reads (rows r, r+1, r+2).
- Issues BRAM reads and drives the window's write enable, one column per cycle.
- Flags when the 9 window taps hold a complete window, with its (row, col) position.
- Applies back-pressure from the downstream MAC array via a valid/ready handshake.

Parameters:
- IMG_W, 28: image width in pixels; must be >= 3.
- IMG_H, 28: image height in pixels; must be >= 3.
- ADDR_W, 10: BRAM address width; must satisfy IMG_W*IMG_H <= 2**ADDR_W.
- CNT_W, 8: width of the row/col counters; must satisfy max(IMG_W, IMG_H) < 2**CNT_W.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: single-cycle pulse; begins a full-image pass; ignored while busy.
- busy, output, 1: high from the cycle after start is accepted until done.
- done, output, 1: one-cycle pulse when the last window has been consumed.
- rd_en, output, 1: BRAM read enable, one column per assertion.
- rd_addr_r1, output, ADDR_W: address row*IMG_W + col.
- rd_addr_r2, output, ADDR_W: rd_addr_r1 + IMG_W.
- rd_addr_r3, output, ADDR_W: rd_addr_r1 + 2*IMG_W.
- win_wr_en, output, 1: shift enable into the window register.
- win_valid, output, 1: window holds a complete 3x3 patch.
- out_ready, input, 1: downstream accepts the window this cycle.
- win_row, output, CNT_W: top-left row index of the current window.
- win_col, output, CNT_W: top-left column index of the current window.

Behaviour:
- Reset: state IDLE. busy, done, rd_en, win_wr_en, win_valid = 0; addresses, win_row, win_col = 0; all counters and the pend flag = 0.
- FSM states: IDLE, FETCH, ROW_END, FIN.
- IDLE:
  - start=1 -> FETCH; row=0, col=0, shift_cnt=0, base address=0.
- FETCH:
  - ok = !(win_valid && !out_ready).
  - In an ok cycle: win_wr_en = pend; rd_en = (col < IMG_W). If rd_en, col++ and the addresses increment by 1.
  - pend <= rd_en (BRAM has 1-cycle read latency).
  - In a non-ok cycle: rd_en=0, win_wr_en=0, and every counter, address and pend holds. BRAM dout is stable because it is not re-read.
  - Each win_wr_en increments shift_cnt.
  - Transition to ROW_END when col==IMG_W and pend==0.
- win_valid (registered):
  - Set on the edge closing a shift cycle where shift_cnt >= 2 (third and later shift of the row). win_col = shift_cnt-2, win_row = row.
  - Otherwise cleared when out_ready=1; otherwise held.
  - A window is transferred in any cycle with win_valid && out_ready.
  - A shift and a transfer may occur in the same cycle: the new window replaces the old one with no bubble.
- ROW_END: wait until win_valid==0 (last window consumed), then:
  - If row == IMG_H-3 -> FIN.
  - Else row++, col=0, shift_cnt=0, base += IMG_W -> FETCH. This costs 1 bubble cycle per row, and no stale-row window is ever flagged.
- FIN: done=1 for one cycle, busy=0 -> IDLE.
- Totals: IMG_W-2 windows per row, (IMG_W-2)*(IMG_H-2) per pass, issued in raster order.
- Latency with out_ready=1: start sampled at edge E0 (cycle 0).
  - Cycle 1: first rd_en.
  - Cycles 2-4: win_wr_en.
  - Cycle 5: first win_valid, then one window per cycle through cycle IMG_W+2.
- Address arithmetic is incremental only; no multiplier.
- start while busy is ignored; the pass is not restarted.
- rst_n asserted mid-pass aborts immediately to the reset state; no done pulse. Window register contents are don't-care afterward.

Test Plan:
- IMG_W=5, IMG_H=4, out_ready=1, start pulse at cycle 0:
  - rd_en in cycles 1-5 with rd_addr_r1 = 0..4, rd_addr_r2 = 5..9, rd_addr_r3 = 10..14.
  - win_valid in cycles 5-7 with win_col = 0, 1, 2 and win_row = 0.
  - 6 windows in total, then a single done pulse.
- Same config, out_ready=0 during cycles 5-8:
  - win_valid held, win_col stays 0, rd_en=0 and win_wr_en=0 during the stall.
  - Transfer order resumes 0, 1, 2 with no window lost or duplicated.
- Row transition: after row 0 ends, rd_addr_r1 restarts at 5.
  - No win_valid until 3 new shifts.
  - Second-row windows report win_row=1, win_col=0..2.
- start re-pulsed mid-pass: ignored; window count stays 6 and exactly one done.
- rst_n low in the middle of row 1: all outputs 0 within the same cycle (async). A subsequent start produces a complete fresh pass of 6 windows.
- IMG_W=3, IMG_H=3: exactly 1 window at (0,0), then done; random out_ready yields the same single transfer.
